// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types and helpers for the MAC accumulator slice.
//  Revision    : 1.0  initial release
// ============================================================================
package mac_pkg;

    // Accumulator FSM, explicitly encoded.
    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } mac_state_t;

    // Sign-magnitude field layout: sign sits at (width - c_SM_SIGN_OFS),
    // magnitude occupies everything from c_SM_MAG_LSB up to just below it.
    localparam int c_SM_SIGN_OFS = 1;
    localparam int c_SM_MAG_LSB  = 0;

    // Wide enough that the sum of num_terms full-scale products never wraps.
    function automatic int acc_width(input int n, input int num_terms);
        return 2 * n + $clog2(num_terms) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_output_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : mac_output_formatter
//  Description : Combinational abs / optional round / shift / saturate / sign
//                fix of the final sum. Define MAC_ROUND_EN for rounding.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_output_formatter
    import mac_pkg::*;
#(
    parameter int N     = 8,
    parameter int Q     = 5,
    parameter int ACC_W = 19
) (
    input  logic [ACC_W-1:0] sum,
    output logic [N-1:0]     result,
    output logic             sat
);

    localparam logic [ACC_W:0] c_MAX = (ACC_W+1)'((2 ** (N - 1)) - 1);

    logic [ACC_W-1:0] w_abs;
    logic [ACC_W:0]   w_rnd;
    logic [ACC_W:0]   w_mag;
    logic [N-2:0]     w_mag_sat;
    logic             w_neg;

    assign w_neg = sum[ACC_W-1];
    assign w_abs = w_neg ? (-sum) : sum;

`ifdef MAC_ROUND_EN
    // Half-LSB bias before the shift gives round half away from zero.
    localparam logic [ACC_W:0] c_HALF = (ACC_W+1)'(1) << (Q - 1);
    assign w_rnd = {1'b0, w_abs} + c_HALF;
`else
    assign w_rnd = {1'b0, w_abs};
`endif

    assign w_mag     = w_rnd >> Q;
    assign sat       = (w_mag > c_MAX);
    assign w_mag_sat = sat ? c_MAX[N-2:0] : w_mag[N-2:0];

    // A zero magnitude is always reported as positive.
    assign result = {w_neg && (w_mag_sat != '0), w_mag_sat};

endmodule
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : mac_accumulator
//  Description : Sums NUM_TERMS sign-magnitude products, then presents a
//                rescaled, saturated N-bit result. Define MAC_ROUND_EN to
//                round instead of truncate.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int N         = 8,
    parameter int Q         = 5,
    parameter int NUM_TERMS = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_product,
    input  logic           in_ovr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_result,
    output logic           out_ovr
);

    localparam int c_ACC_W  = acc_width(N, NUM_TERMS);
    localparam int c_CNT_W  = $clog2(NUM_TERMS);
    localparam int c_MAG_W  = 2 * N - c_SM_SIGN_OFS;
    localparam int c_SIGN_I = 2 * N - c_SM_SIGN_OFS;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NUM_TERMS - 1);

    mac_state_t         r_state;
    mac_state_t         w_state_nxt;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovr_sticky;
    logic [N-1:0]       r_result;
    logic               r_out_ovr;

    logic [c_ACC_W-1:0] w_mag_ext;
    logic [c_ACC_W-1:0] w_term;
    logic [c_ACC_W-1:0] w_acc_sum;
    logic               w_accept;
    logic               w_last;
    logic               w_out_hs;
    logic [N-1:0]       w_fmt_result;
    logic               w_fmt_sat;

    assign w_mag_ext = {{(c_ACC_W - c_MAG_W){1'b0}}, in_product[c_MAG_W-1:c_SM_MAG_LSB]};
    assign w_term    = in_product[c_SIGN_I] ? (-w_mag_ext) : w_mag_ext;
    assign w_acc_sum = r_acc + w_term;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = w_accept && (r_cnt == c_LAST);
    assign w_out_hs  = out_valid && out_ready;

    mac_output_formatter #(
        .N     (N),
        .Q     (Q),
        .ACC_W (c_ACC_W)
    ) u_fmt (
        .sum    (w_acc_sum),
        .result (w_fmt_result),
        .sat    (w_fmt_sat)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (w_last) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_ACC;
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    // The result is captured from the sum including the final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ACC;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovr_sticky <= 1'b0;
            r_result     <= '0;
            r_out_ovr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_acc        <= w_acc_sum;
                r_cnt        <= r_cnt + c_CNT_W'(1);
                r_ovr_sticky <= r_ovr_sticky | in_ovr;
                if (w_last) begin
                    r_result  <= w_fmt_result;
                    r_out_ovr <= r_ovr_sticky | in_ovr | w_fmt_sat;
                end
            end else if (w_out_hs) begin
                r_acc        <= '0;
                r_cnt        <= '0;
                r_ovr_sticky <= 1'b0;
            end
        end
    end

    assign out_result = r_result;
    assign out_ovr    = r_out_ovr;

endmodule
`default_nettype wire

// File: doc/mac_accumulator.md
# mac_accumulator

Accumulates a fixed number of signed fixed-point products into one neuron pre-activation sum, one product per beat, then emits a rescaled, saturated N-bit result. Sits directly downstream of the fixed-point multiplier in the multiply-accumulate path and consumes its {sign, magnitude} product and overflow flag. Its result feeds the CORDIC activation stage.

## Interface
- N, 8: output word width; sign-magnitude, 1 sign bit plus N-1 magnitude bits
- Q, 5: fractional bits of the output; input products carry 2Q fractional bits
- NUM_TERMS, 4: products per result, at least 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  product beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_product  input  2N  bit 2N-1 is the sign, bits 2N-2:0 are the magnitude with 2Q fractional bits
- in_ovr  input  1  multiplier overflow flag for this beat
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_result  output  N  sign-magnitude result with Q fractional bits
- out_ovr  output  1  an input overflowed, or the result saturated

## Operation
- Accumulator width ACC_W = 2N + clog2(NUM_TERMS) + 1. It is two's complement and never wraps.
- Each accepted beat is converted from sign-magnitude to two's complement and added to the accumulator.
- States:
  - ACC: in_ready=1, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
- Transitions:
  - When ACC accepts beat number NUM_TERMS, it moves to OUT.
  - When OUT sees out_ready=1, it moves to ACC. On the same edge the accumulator, beat counter and sticky overflow clear.
- A beat is accepted when in_valid && in_ready. The beat counter counts 0..NUM_TERMS-1.
- Output formatting is computed from the final sum and registered on the edge that enters OUT:
  - magnitude = |sum| >> Q
  - if magnitude > 2^(N-1)-1, clamp it to 2^(N-1)-1 and set the saturation flag
  - sign = sum<0, but forced to 0 when the final magnitude is 0 (no negative zero)
- Shifting |sum| truncates toward zero unless rounding is configured.
- out_ovr = (OR of in_ovr over the NUM_TERMS accepted beats) | saturation flag.
- In OUT, in_valid is ignored and no beat is consumed.

## Timing
- Reset values:
  - state=ACC, accumulator=0, counter=0
  - in_ready=1, out_valid=0, out_result=0, out_ovr=0
- Latency: out_valid rises on the cycle after the last beat is accepted.
- Throughput: one result every NUM_TERMS+1 cycles at best.
- out_result and out_ovr are registered and stay stable while out_valid && !out_ready.
- in_ready=1 in the cycle after the output handshake.
- Reset asserted mid-accumulation: the partial sum is discarded, and the next NUM_TERMS beats form a fresh result.
- Beats with in_valid=0 do not advance the counter. Gaps between beats are allowed.

## Configuration
- MAC_ROUND_EN defined: add 2^(Q-1) to |sum| before the right shift (round half away from zero). Saturation is applied after rounding.
- MAC_ROUND_EN undefined: truncate toward zero, with no adder.

## Structure
- Package mac_pkg holds:
  - the state enum (ACC, OUT)
  - an acc_width(N, NUM_TERMS) function
  - the sign-magnitude field index constants
- Sub-module mac_output_formatter is purely combinational: abs, optional round, shift, saturate and sign fix. It is instantiated once.

## Test plan
All cases use N=8, Q=5, NUM_TERMS=4.
- Beats 16'h0400, 16'h0400, 16'h8400, 16'h0200 (in_ovr=0) -> out_result=8'h30 (1.5), out_ovr=0, out_valid exactly one cycle after the 4th beat.
- Four beats of 16'h0400 -> sum 4096, out_result=8'h7F, out_ovr=1 (saturation).
- Beats 16'h8010, 0, 0, 0:
  - without MAC_ROUND_EN -> out_result=8'h00 (no negative zero)
  - with MAC_ROUND_EN -> 8'h81
  - the same test with 16'h0010 -> 8'h00 without rounding, 8'h01 with rounding.
- Valid result with out_ready held low for 3 cycles while in_valid=1:
  - out_result and out_ovr stay stable, in_ready=0, no beats are consumed
  - after the handshake the next 4 beats produce an independent result.
- Assert rst after 2 beats of 16'h7FFF, then send 16'h0400, 16'h0400, 0, 0 -> out_result=8'h40, out_ovr=0.
- Assert in_ovr=1 on beat 3 only, all products 0 -> out_result=8'h00, out_ovr=1. The following result with clean beats has out_ovr=0.
